// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit counter must reach WIDTH, hence WIDTH+1 states.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bo = borrow out. Purely combinational.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    full_subtractor_cell u_cell (
        .a   (r_a_sr[0]),
        .b   (r_b_sr[0]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // New bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign w_work_nxt = w_d;
        end else begin : g_work_wn
            assign w_work_nxt = {w_d, r_work[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= bin;
                        r_work   <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_work   <= w_work_nxt;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        diff <= w_work_nxt;
                        bout <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand MSBs differ and result sign differs from a.
                        ovf  <= (r_a_sr[0] ^ r_b_sr[0]) & (w_d ^ r_a_sr[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       s1_start;
    logic [0:0] s1_a;
    logic [0:0] s1_b;
    logic       s1_bin;
    logic       s1_busy;
    logic       s1_done;
    logic [0:0] s1_diff;
    logic       s1_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       s1_ovf;
`endif

    int n_cmp;
    int n_err;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
        .a     (s1_a),
        .b     (s1_b),
        .bin   (s1_bin),
        .busy  (s1_busy),
        .done  (s1_done),
        .diff  (s1_diff),
        .bout  (s1_bout)
`ifdef SERIAL_SUB_OVF_EN
       ,.ovf   (s1_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Drive one request; operands are scrambled right after the accepting edge.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
    endtask

    // Cycles (negedges after the accepting edge) until done; -1 on timeout.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc = -1;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0; a = 8'd0; b = 8'd0; bin = 1'b0;
        s1_start = 1'b0; s1_a = 1'b0; s1_b = 1'b0; s1_bin = 1'b0;
        #3;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (diff !== 8'h00) begin n_err++; $display("FAIL reset_diff got %h want 00", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got %b want 0", bout); end
        n_cmp++; if ({s1_busy, s1_done, s1_diff, s1_bout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_w1 got %b want 0000", {s1_busy, s1_done, s1_diff, s1_bout});
        end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int cyc;
        int nb;
        launch(8'd100, 8'd37, 1'b0);
        wait_done(cyc, nb);
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL basic_latency got %0d want 8", cyc); end
        n_cmp++; if (nb !== 8) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 8", nb); end
        n_cmp++; if (diff !== 8'd63) begin n_err++; $display("FAIL basic_diff got %0d want 63", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL basic_bout got %b want 0", bout); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_cmp++; if (diff !== 8'd63) begin n_err++; $display("FAIL basic_diff_hold got %0d want 63", diff); end
    endtask

    task automatic test_borrow;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vbin [3];
        logic [7:0] ed [3];
        logic       eb [3];
        int cyc;
        int nb;
        va[0] = 8'd5;   vb[0] = 8'd9;   vbin[0] = 1'b0; ed[0] = 8'hFC; eb[0] = 1'b1;
        va[1] = 8'd0;   vb[1] = 8'd0;   vbin[1] = 1'b1; ed[1] = 8'hFF; eb[1] = 1'b1;
        va[2] = 8'd200; vb[2] = 8'd100; vbin[2] = 1'b1; ed[2] = 8'd99; eb[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i], vbin[i]);
            wait_done(cyc, nb);
            n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL borrow%0d_latency got %0d want 8", i, cyc); end
            n_cmp++; if (diff !== ed[i]) begin n_err++; $display("FAIL borrow%0d_diff got %h want %h", i, diff, ed[i]); end
            n_cmp++; if (bout !== eb[i]) begin n_err++; $display("FAIL borrow%0d_bout got %b want %b", i, bout, eb[i]); end
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        ndone = 0;
        @(negedge clk);
        a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd7; b = 8'd9; bin = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 4) begin
                n_cmp++; if (diff !== 8'd99) begin n_err++; $display("FAIL ign_diff_hold got %0d want 99", diff); end
            end
            if (k == 8) begin
                n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done1 got %b want 1", done); end
                n_cmp++; if (diff !== 8'd30) begin n_err++; $display("FAIL ign_diff1 got %0d want 30", diff); end
                n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL ign_bout1 got %b want 0", bout); end
            end
            if (k == 9) begin
                n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy got %b want 0", busy); end
            end
            if (k == 10) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_reaccept_busy got %b want 1", busy); end
            end
            if (k == 18) begin
                n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done2 got %b want 1", done); end
                n_cmp++; if (diff !== 8'hFE) begin n_err++; $display("FAIL ign_diff2 got %h want fe", diff); end
                n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL ign_bout2 got %b want 1", bout); end
                n_cmp++; if (ndone !== 2) begin n_err++; $display("FAIL ign_done_count got %0d want 2", ndone); end
                start = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_done_after got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int nb;
        launch(8'd100, 8'd37, 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b want 0", done); end
        n_cmp++; if (diff !== 8'h00) begin n_err++; $display("FAIL rmid_diff got %h want 00", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL rmid_bout got %b want 0", bout); end
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd200, 8'd55, 1'b0);
        wait_done(cyc, nb);
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL rmid_latency got %0d want 8", cyc); end
        n_cmp++; if (diff !== 8'd145) begin n_err++; $display("FAIL rmid_diff_after got %0d want 145", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL rmid_bout_after got %b want 0", bout); end
    endtask

    task automatic test_width1;
        logic [7:0] exp_d;
        logic [7:0] exp_bo;
        logic [2:0] v;
        exp_d  = 8'b1001_0110;
        exp_bo = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            s1_a = v[2]; s1_b = v[1]; s1_bin = v[0]; s1_start = 1'b1;
            @(posedge clk);
            #1;
            s1_start = 1'b0; s1_a = ~v[2]; s1_b = ~v[1]; s1_bin = ~v[0];
            @(negedge clk);
            n_cmp++; if ({s1_busy, s1_done} !== 2'b10) begin
                n_err++; $display("FAIL w1_run%0d busy/done got %b want 10", i, {s1_busy, s1_done});
            end
            @(negedge clk);
            n_cmp++; if (s1_done !== 1'b1) begin n_err++; $display("FAIL w1_done%0d got %b want 1", i, s1_done); end
            n_cmp++; if (s1_diff[0] !== exp_d[i]) begin n_err++; $display("FAIL w1_diff%0d got %b want %b", i, s1_diff, exp_d[i]); end
            n_cmp++; if (s1_bout !== exp_bo[i]) begin n_err++; $display("FAIL w1_bout%0d got %b want %b", i, s1_bout, exp_bo[i]); end
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        int cyc;
        int nb;
        launch(8'h80, 8'h01, 1'b0);
        wait_done(cyc, nb);
        n_cmp++; if (diff !== 8'h7F) begin n_err++; $display("FAIL ovf0_diff got %h want 7f", diff); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf0_ovf got %b want 1", ovf); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL ovf0_bout got %b want 0", bout); end
        launch(8'h10, 8'h01, 1'b0);
        wait_done(cyc, nb);
        n_cmp++; if (diff !== 8'h0F) begin n_err++; $display("FAIL ovf1_diff got %h want 0f", diff); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf1_ovf got %b want 0", ovf); end
        launch(8'h7F, 8'hFF, 1'b0);
        wait_done(cyc, nb);
        n_cmp++; if (diff !== 8'h80) begin n_err++; $display("FAIL ovf2_diff got %h want 80", diff); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf2_ovf got %b want 1", ovf); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL ovf2_bout got %b want 1", bout); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignored_start();
        test_reset_mid();
        test_width1();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple subtractor: computes a - b - bin one bit per clock, LSB first, through a single registered full-subtractor cell.
- Counterpart of the combinational full-adder datapath: same bit cell family, but it subtracts and iterates over time instead of replicating the cell in space.
- Sits beside the adder blocks as the low-area arithmetic option for multi-cycle datapaths; controlled by a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result register.
- bout  output  1  final borrow-out.

Behaviour:
- States: IDLE, RUN, DONE. Counter width is $clog2(WIDTH+1).
- Reset: while rst_n is low, state = IDLE; busy, done, diff and bout are 0; shift registers, borrow flop and counter are 0. Reset applies immediately (asynchronous) and aborts any operation in progress. No partial result is kept.
- IDLE:
  - With start = 1 at an edge: load a and b into shift registers, load bin into the borrow flop, clear the counter, go to RUN.
  - With start = 0: stay in IDLE.
- RUN: each edge processes the current bit (a0 = a_sr[0], b0 = b_sr[0], br = borrow flop):
  - d = a0 ^ b0 ^ br
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the MSB of the working result register. Shift a_sr and b_sr right by one. Increment the counter.
  - On the edge that processes bit WIDTH-1: copy the working result into diff and borrow_next into bout, then go to DONE.
- DONE: done = 1 for exactly one cycle, then the next edge returns to IDLE.
- Latency: start is accepted at edge 0. done is high during the cycle after edge WIDTH and low after edge WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Output timing:
  - busy = (state == RUN).
  - diff and bout change only on entry to DONE, and hold their value through IDLE and the following RUN.
- start while in RUN or DONE: ignored, with no queuing. The operand inputs may change freely outside the accepting edge.
- WIDTH = 1: exactly one RUN cycle.
- Arithmetic: the result is modulo 2^WIDTH. bout = 1 exactly when a < b + bin, treating a and b as unsigned.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset to 0.
  - ovf = 1 when the signed two's-complement result overflowed: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - Evaluated on the MSB RUN cycle and registered with diff; holds its value like diff.
- Undefined: no ovf port and no extra flops. All other behaviour is identical.

Decomposition:
- Shared package (serial_arith_pkg):
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH constant.
  - Counter-width function based on $clog2.
- One sub-module, full_subtractor_cell: purely combinational; inputs a, b, bin; outputs d, bo. It mirrors the full-adder cell and is instantiated once.
- The FSM, shift registers and output registers live in the top module.

Test Plan:
- Basic timing: WIDTH = 8, a = 100, b = 37, bin = 0, start pulse → diff = 63, bout = 0. done is high for exactly one cycle, 8 cycles after the accepting edge. busy is high for 8 cycles.
- Borrow out: a = 5, b = 9, bin = 0 → diff = 8'hFC, bout = 1. Then a = 0, b = 0, bin = 1 → diff = 8'hFF, bout = 1.
- Ignored start: assert start continuously through RUN with different operands → only the first operands are used, with one done per operation. The next operation is accepted only in IDLE, WIDTH+2 cycles after the first accept.
- Reset mid-operation: drive rst_n low at RUN bit 4 → busy, done, diff and bout drop to 0 immediately, with no clock needed. After release, a new start produces a correct result.
- Overflow (SERIAL_SUB_OVF_EN defined): a = 8'h80, b = 8'h01 → diff = 8'h7F, ovf = 1, bout = 0. Then a = 8'h10, b = 8'h01 → ovf = 0.
- WIDTH = 1 build, all 8 combinations of {a, b, bin}: diff and bout match the full-subtractor truth table, with done high one cycle after accept.
